// File: rtl/cpu_cycle_sequencer_if.sv
// Unified-memory request bus between the cycle sequencer (master) and the
// single-port memory (slave).
interface cpu_cycle_sequencer_if;
    logic mem_req;
    logic mem_sel;
    logic mem_we;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_sel,
        output mem_we,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_sel,
        input  mem_we,
        output mem_ready
    );
endinterface : cpu_cycle_sequencer_if

// File: rtl/cpu_cycle_sequencer.sv
// Multi-cycle sequencer: time-shares one memory between fetch and data access,
// gates CU strobes per phase, supports free-run/single-step and halts on SYSTEM.
module cpu_cycle_sequencer #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run_mode,
    input  logic                    step,
    input  logic                    cu_mem_read,
    input  logic                    cu_mem_write,
    input  logic                    cu_reg_write,
    input  logic                    cu_pc_load,
    cpu_cycle_sequencer_if.master   mem,
    output logic                    ir_load,
    output logic                    reg_write_en,
    output logic                    pc_write_en,
    output logic                    halted,
    output logic                    mem_err,
    output logic [2:0]              state,
    output logic [CNT_W-1:0]        instr_count
);

    localparam int unsigned WAIT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    state_e              state_q;
    logic [WAIT_W-1:0]   wait_q;
    logic [CNT_W-1:0]    count_q;
    logic                err_q;
    logic                timeout_hit;

    // Last permitted wait cycle: a miss here is the TIMEOUT-th miss.
    assign timeout_hit = (wait_q == WAIT_W'(TIMEOUT - 1));

    // Sequencer state, wait counter, retire counter and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    wait_q <= '0;
                    if (run_mode || step) state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (mem.mem_ready) begin
                        wait_q  <= '0;
                        state_q <= S_DECODE;
                    end else if (timeout_hit) begin
                        state_q <= S_HALT;
                        err_q   <= 1'b1;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    wait_q <= '0;
                    if (!cu_pc_load)                       state_q <= S_HALT;
                    else if (cu_mem_read || cu_mem_write)  state_q <= S_MEM;
                    else                                   state_q <= S_WB;
                end
                S_MEM: begin
                    if (mem.mem_ready) begin
                        wait_q  <= '0;
                        state_q <= S_WB;
                    end else if (timeout_hit) begin
                        state_q <= S_HALT;
                        err_q   <= 1'b1;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                S_WB: begin
                    wait_q  <= '0;
                    count_q <= count_q + CNT_W'(1);
                    state_q <= run_mode ? S_FETCH : S_IDLE;
                end
                S_HALT: begin
                    wait_q <= '0;
                end
                default: begin
                    state_q <= S_HALT;
                end
            endcase
        end
    end

    // Per-phase strobes; forced low while reset is asserted.
    always_comb begin
        mem.mem_req  = 1'b0;
        mem.mem_sel  = 1'b0;
        mem.mem_we   = 1'b0;
        ir_load      = 1'b0;
        reg_write_en = 1'b0;
        pc_write_en  = 1'b0;
        halted       = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem.mem_req = 1'b1;
                    ir_load     = mem.mem_ready;
                end
                S_MEM: begin
                    mem.mem_req = 1'b1;
                    mem.mem_sel = 1'b1;
                    mem.mem_we  = cu_mem_write;
                end
                S_WB: begin
                    reg_write_en = cu_reg_write;
                    pc_write_en  = 1'b1;
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    halted = 1'b0;
                end
            endcase
        end
    end

    assign state       = 3'(state_q);
    assign instr_count = count_q;
    assign mem_err     = err_q;

endmodule : cpu_cycle_sequencer

// File: tb/tb_cpu_cycle_sequencer.sv
// Scoreboard bench for cpu_cycle_sequencer: directed stimulus pushes the
// hand-computed per-cycle response, a negedge monitor pops and compares.
module tb_cpu_cycle_sequencer;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned TIMEOUT = 4;

    // strobe vector: {mem_req, mem_sel, mem_we, ir_load, reg_write_en, pc_write_en, halted}
    localparam logic [6:0] N   = 7'b0000000;
    localparam logic [6:0] FW  = 7'b1000000;
    localparam logic [6:0] FR  = 7'b1001000;
    localparam logic [6:0] MR  = 7'b1100000;
    localparam logic [6:0] MW  = 7'b1110000;
    localparam logic [6:0] WBR = 7'b0000110;
    localparam logic [6:0] WBN = 7'b0000010;
    localparam logic [6:0] H   = 7'b0000001;

    // cu vector: {mem_read, mem_write, reg_write, pc_load}
    localparam logic [3:0] ALU = 4'b0011;
    localparam logic [3:0] ST  = 4'b0101;
    localparam logic [3:0] LD  = 4'b1011;
    localparam logic [3:0] RW  = 4'b1111;
    localparam logic [3:0] SYS = 4'b0000;

    logic             clk;
    logic             rst;
    logic             run_mode;
    logic             step;
    logic             cu_mem_read;
    logic             cu_mem_write;
    logic             cu_reg_write;
    logic             cu_pc_load;
    logic             ir_load;
    logic             reg_write_en;
    logic             pc_write_en;
    logic             halted;
    logic             mem_err;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_count;

    cpu_cycle_sequencer_if bus ();

    cpu_cycle_sequencer #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run_mode     (run_mode),
        .step         (step),
        .cu_mem_read  (cu_mem_read),
        .cu_mem_write (cu_mem_write),
        .cu_reg_write (cu_reg_write),
        .cu_pc_load   (cu_pc_load),
        .mem          (bus.master),
        .ir_load      (ir_load),
        .reg_write_en (reg_write_en),
        .pc_write_en  (pc_write_en),
        .halted       (halted),
        .mem_err      (mem_err),
        .state        (state),
        .instr_count  (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [14:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic logic [14:0] pack_exp(input logic [2:0] st, input logic [6:0] str,
                                             input logic err, input logic [3:0] cnt);
        return {st, str, err, cnt};
    endfunction

    // Monitor: compare every cycle that has a pending expectation.
    always @(negedge clk) begin
        logic [14:0] e;
        logic [14:0] g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {state, bus.mem_req, bus.mem_sel, bus.mem_we, ir_load, reg_write_en,
                 pc_write_en, halted, mem_err, instr_count};
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL cycle_check #%0d @%0t: got st=%0d str=%b err=%b cnt=%0d, required st=%0d str=%b err=%b cnt=%0d",
                         n_cmp, $time, g[14:12], g[11:5], g[4], g[3:0],
                         e[14:12], e[11:5], e[4], e[3:0]);
            end
        end
    end

    task automatic drive(input logic run, input logic stp, input logic rdy, input logic [3:0] cu);
        run_mode      = run;
        step          = stp;
        bus.mem_ready = rdy;
        {cu_mem_read, cu_mem_write, cu_reg_write, cu_pc_load} = cu;
    endtask

    // One clock cycle: apply inputs just after the edge, queue the expected response.
    task automatic cyc(input logic run, input logic stp, input logic rdy, input logic [3:0] cu,
                       input logic [2:0] st, input logic [6:0] str, input logic err,
                       input logic [3:0] cnt);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(run, stp, rdy, cu);
        exp_q.push_back(pack_exp(st, str, err, cnt));
    endtask

    // Hold reset for one cycle with active-looking inputs; everything must read idle.
    task automatic do_reset(input logic run, input logic [3:0] cu);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(run, 1'b1, 1'b1, cu);
        exp_q.push_back(pack_exp(3'd0, N, 1'b0, 4'd0));
    endtask

    task automatic step_alu(input logic [3:0] c);
        cyc(0, 1, 1, ALU, 3'd0, N,   0, c);
        cyc(0, 0, 1, ALU, 3'd1, FR,  0, c);
        cyc(0, 0, 1, ALU, 3'd2, N,   0, c);
        cyc(0, 0, 1, ALU, 3'd4, WBR, 0, c);
        cyc(0, 0, 1, ALU, 3'd0, N,   0, c + 4'd1);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, SYS);

        // free-run ALU stream, counter wraps after 16 retirements
        do_reset(1, ALU);
        cyc(1, 0, 1, ALU, 3'd0, N, 0, 4'd0);
        for (int i = 0; i < 16; i++) begin
            cyc(1, 0, 1, ALU, 3'd1, FR,  0, 4'(i));
            cyc(1, 0, 1, ALU, 3'd2, N,   0, 4'(i));
            cyc(1, 0, 1, ALU, 3'd4, WBR, 0, 4'(i));
        end
        // run_mode drops during fetch: instruction completes, then IDLE
        cyc(0, 0, 1, ALU, 3'd1, FR,  0, 4'd0);
        cyc(0, 0, 1, ALU, 3'd2, N,   0, 4'd0);
        cyc(0, 0, 1, ALU, 3'd4, WBR, 0, 4'd0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 1, ALU, 3'd0, N, 0, 4'd1);

        // single step with a stray step pulse in DECODE
        cyc(0, 1, 1, ALU, 3'd0, N,   0, 4'd1);
        cyc(0, 0, 1, ALU, 3'd1, FR,  0, 4'd1);
        cyc(0, 1, 1, ALU, 3'd2, N,   0, 4'd1);
        cyc(0, 0, 1, ALU, 3'd4, WBR, 0, 4'd1);
        cyc(0, 0, 1, ALU, 3'd0, N,   0, 4'd2);
        cyc(0, 0, 1, ALU, 3'd0, N,   0, 4'd2);

        // store, memory stalls two cycles
        cyc(0, 1, 1, ST, 3'd0, N,   0, 4'd2);
        cyc(0, 0, 1, ST, 3'd1, FR,  0, 4'd2);
        cyc(0, 0, 1, ST, 3'd2, N,   0, 4'd2);
        cyc(0, 0, 0, ST, 3'd3, MW,  0, 4'd2);
        cyc(0, 0, 0, ST, 3'd3, MW,  0, 4'd2);
        cyc(0, 0, 1, ST, 3'd3, MW,  0, 4'd2);
        cyc(0, 0, 1, ST, 3'd4, WBN, 0, 4'd2);
        cyc(0, 0, 1, ST, 3'd0, N,   0, 4'd3);

        // free-run load, 4 cycles, run dropped at WB
        cyc(1, 0, 1, LD, 3'd0, N,   0, 4'd3);
        cyc(1, 0, 1, LD, 3'd1, FR,  0, 4'd3);
        cyc(1, 0, 1, LD, 3'd2, N,   0, 4'd3);
        cyc(1, 0, 1, LD, 3'd3, MR,  0, 4'd3);
        cyc(0, 0, 1, LD, 3'd4, WBR, 0, 4'd3);
        cyc(0, 0, 1, LD, 3'd0, N,   0, 4'd4);

        // read+write: write priority; ready on the TIMEOUT-th cycle in both FETCH and MEM
        cyc(0, 1, 0, RW, 3'd0, N, 0, 4'd4);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, RW, 3'd1, FW, 0, 4'd4);
        cyc(0, 0, 1, RW, 3'd1, FR, 0, 4'd4);
        cyc(0, 0, 1, RW, 3'd2, N,  0, 4'd4);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, RW, 3'd3, MW, 0, 4'd4);
        cyc(0, 0, 1, RW, 3'd3, MW,  0, 4'd4);
        cyc(0, 0, 1, RW, 3'd4, WBR, 0, 4'd4);
        cyc(0, 0, 1, RW, 3'd0, N,   0, 4'd5);

        // SYSTEM halt; run_mode and step are ignored afterwards
        cyc(0, 1, 1, SYS, 3'd0, N,  0, 4'd5);
        cyc(0, 0, 1, SYS, 3'd1, FR, 0, 4'd5);
        cyc(0, 0, 1, SYS, 3'd2, N,  0, 4'd5);
        for (int i = 0; i < 4; i++) cyc(1, 1, 1, ALU, 3'd5, H, 0, 4'd5);

        // fetch timeout -> HALT with mem_err
        do_reset(0, ALU);
        step_alu(4'd0);
        cyc(0, 1, 0, ALU, 3'd0, N, 0, 4'd1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, ALU, 3'd1, FW, 0, 4'd1);
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, ALU, 3'd5, H, 1, 4'd1);

        // asynchronous reset in the middle of a MEM cycle
        do_reset(0, ALU);
        step_alu(4'd0);
        cyc(0, 1, 1, LD, 3'd0, N,  0, 4'd1);
        cyc(0, 0, 1, LD, 3'd1, FR, 0, 4'd1);
        cyc(0, 0, 1, LD, 3'd2, N,  0, 4'd1);
        cyc(0, 0, 0, LD, 3'd3, MR, 0, 4'd1);
        @(posedge clk);
        #1;
        drive(0, 0, 0, LD);
        #2;
        rst = 1'b1;
        exp_q.push_back(pack_exp(3'd0, N, 1'b0, 4'd0));
        cyc(0, 0, 1, LD, 3'd0, N, 0, 4'd0);

        repeat (3) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_cpu_cycle_sequencer

// File: doc/cpu_cycle_sequencer.md
Name: cpu_cycle_sequencer

Overview:
- Multi-cycle sequencer for the RISC-V core on the Nexys A7.
- Time-shares one single-port unified memory between instruction fetch and data access.
- Gates the CU's decoded strobes (MemRead, MemWrite, RegWrite, PC_load) into per-phase enables.
- Supports free-run and single-step (board button) execution, halts on SYSTEM, and counts retired instructions for the display.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- TIMEOUT, 255, max cycles spent waiting for mem_ready in one access before a memory-error halt (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- run_mode  in  1  1 = free-run, 0 = single-step.
- step  in  1  single-cycle pulse (already debounced/edge-detected); starts one instruction in step mode.
- cu_mem_read  in  1  CU MemRead for the current IR.
- cu_mem_write  in  1  CU MemWrite for the current IR.
- cu_reg_write  in  1  CU RegWrite for the current IR.
- cu_pc_load  in  1  CU PC_load; 0 = SYSTEM/halt instruction.
- mem_ready  in  1  memory access complete this cycle.
- mem_req  out  1  memory access request.
- mem_sel  out  1  address mux select: 0 = PC (fetch), 1 = ALU result (data).
- mem_we  out  1  memory write enable.
- ir_load  out  1  IR capture strobe.
- reg_write_en  out  1  register-file write enable.
- pc_write_en  out  1  PC update enable.
- halted  out  1  sequencer in HALT.
- mem_err  out  1  sticky; HALT entered by timeout.
- state  out  3  current state code, for debug LEDs.
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 are illegal and go to HALT next cycle.
- Reset: state=IDLE, instr_count=0, mem_err=0, wait counter=0. All strobes are 0 while rst is high, including mid-access.
- All outputs are decoded from the state register and current inputs. State, counters and mem_err are registered.
- IDLE: no strobes. Go to FETCH if run_mode=1, or if step=1.
- FETCH: mem_req=1, mem_sel=0, mem_we=0.
  - mem_ready=1: ir_load=1 in the same cycle; go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle, no strobes; the CU settles on the new IR.
  - cu_pc_load=0: go to HALT.
  - Else cu_mem_read or cu_mem_write set: go to MEM.
  - Else: go to WB.
  - cu_mem_read and cu_mem_write both set: MEM with write priority (mem_we=1).
- MEM: mem_req=1, mem_sel=1, mem_we=cu_mem_write. Wait for mem_ready, then go to WB.
- WB: one cycle.
  - reg_write_en=cu_reg_write, pc_write_en=1.
  - instr_count increments, wrapping from 2^CNT_W-1 to 0.
  - Next state is FETCH if run_mode=1, else IDLE.
- HALT: halted=1, no strobes, pc_write_en=0. Exit only via rst.
- Timeout:
  - The wait counter clears on entry to FETCH or MEM and increments each cycle in that state with mem_ready=0.
  - When it reaches TIMEOUT with mem_ready still 0: go to HALT and set mem_err=1.
  - mem_ready=1 on the TIMEOUT-th cycle counts as success.
- Latency with mem_ready tied high:
  - ALU/branch/jump: 3 cycles (FETCH, DECODE, WB).
  - Load/store: 4 cycles.
- run_mode dropping mid-instruction: the current instruction completes, then the sequencer returns to IDLE.
- step pulses outside IDLE are ignored. A step coinciding with run_mode=1 in IDLE has the same effect as run_mode alone.
- pc_write_en and ir_load never assert in the same cycle. mem_we asserts only in MEM.

Test Plan:
- Reset, run_mode=1, mem_ready=1, ALU op (cu_reg_write=1, cu_pc_load=1), 4 instrs → state sequence 0,1,2,4 repeating 1,2,4; reg_write_en and pc_write_en pulse every 3rd cycle; instr_count=4 after 12 cycles.
- Store (cu_mem_write=1), mem_ready low 2 cycles in MEM → MEM lasts 3 cycles with mem_sel=1, mem_we=1; WB with reg_write_en=0, pc_write_en=1; count +1.
- run_mode=0: no activity for 20 cycles; one step pulse → exactly one instruction executed, then back in IDLE, count +1; a step pulse during DECODE is ignored.
- SYSTEM (cu_pc_load=0) → DECODE goes to HALT, halted=1, pc_write_en never asserts, count unchanged; run_mode and step have no effect until rst.
- mem_ready held 0 in FETCH, TIMEOUT=4 → HALT after 4 cycles, mem_err=1. Async rst mid-MEM → immediate IDLE, mem_req=0, mem_err=0, instr_count=0.
- CNT_W=4, 16 ALU instrs from reset → instr_count wraps to 0.
